// File: rtl/data_mem_arbiter_pkg.sv
// rtl/data_mem_arbiter_pkg.sv - shared state encodings and requester ids for the data memory arbiter
package data_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   typedef logic req_id_t;

   localparam req_id_t REQ_A = 1'b0;
   localparam req_id_t REQ_B = 1'b1;

   function automatic req_id_t other_side(input req_id_t id);
      return ~id;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant with its priority pointer
module rr_arbiter2
   import data_mem_arbiter_pkg::*;
(
   input  logic    clk,
   input  logic    reset,
   input  logic    a_req,
   input  logic    b_req,
   input  logic    upd_en,
   input  req_id_t served_id,
   output logic    grant_valid,
   output req_id_t grant_id
);

   req_id_t ptr_q, ptr_d;

   always_comb begin
      // The pointer names whoever was not just served, so a waiting side always goes next
      ptr_d       = upd_en ? other_side(served_id) : ptr_q;
      grant_valid = a_req | b_req;
      if (a_req && b_req) begin
         grant_id = ptr_q;
      end else if (b_req) begin
         grant_id = REQ_B;
      end else begin
         grant_id = REQ_A;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= REQ_A;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - serialises two requesters onto the single-port data memory
module data_mem_arbiter
   import data_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic              aReq,
   input  logic              aWrite,
   input  logic [ADDR_W-1:0] aAddr,
   input  logic [DATA_W-1:0] aWdata,
   output logic              aDone,
   output logic [DATA_W-1:0] aRdata,
   input  logic              bReq,
   input  logic              bWrite,
   input  logic [ADDR_W-1:0] bAddr,
   input  logic [DATA_W-1:0] bWdata,
   output logic              bDone,
   output logic [DATA_W-1:0] bRdata,
   output logic              memWrite,
   output logic              memRead,
   output logic [ADDR_W-1:0] memAddress,
   output logic [DATA_W-1:0] memWriteData,
   input  logic [DATA_W-1:0] memReadData
);

   state_t            state_q, state_d;
   req_id_t           id_q, id_d;
   logic              mem_write_q, mem_write_d;
   logic              mem_read_q, mem_read_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              a_done_q, a_done_d;
   logic              b_done_q, b_done_d;
   logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
   logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

   logic    grant_valid;
   req_id_t grant_id;
   logic    upd_en;
   logic    sel_write;

   rr_arbiter2 u_arb (
      .clk         (Clk),
      .reset       (reset),
      .a_req       (aReq),
      .b_req       (bReq),
      .upd_en      (upd_en),
      .served_id   (id_q),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   always_comb begin
      state_d     = state_q;
      id_d        = id_q;
      mem_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      a_done_d    = 1'b0;
      b_done_d    = 1'b0;
      a_rdata_d   = a_rdata_q;
      b_rdata_d   = b_rdata_q;
      upd_en      = 1'b0;
      sel_write   = (grant_id == REQ_B) ? bWrite : aWrite;
      case (state_q)
         IDLE: begin
            // The command registers double as the field latches, so later request changes are ignored
            if (grant_valid) begin
               id_d        = grant_id;
               mem_write_d = sel_write;
               mem_read_d  = ~sel_write;
               mem_addr_d  = (grant_id == REQ_B) ? bAddr : aAddr;
               if (sel_write) begin
                  mem_wdata_d = (grant_id == REQ_B) ? bWdata : aWdata;
               end
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (mem_read_q) begin
               if (id_q == REQ_A) begin
                  a_rdata_d = memReadData;
               end else begin
                  b_rdata_d = memReadData;
               end
            end
            a_done_d = (id_q == REQ_A);
            b_done_d = (id_q == REQ_B);
            state_d  = DONE;
         end
         DONE: begin
            upd_en  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         state_q     <= IDLE;
         id_q        <= REQ_A;
         mem_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         a_done_q    <= 1'b0;
         b_done_q    <= 1'b0;
         a_rdata_q   <= '0;
         b_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         id_q        <= id_d;
         mem_write_q <= mem_write_d;
         mem_read_q  <= mem_read_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         a_done_q    <= a_done_d;
         b_done_q    <= b_done_d;
         a_rdata_q   <= a_rdata_d;
         b_rdata_q   <= b_rdata_d;
      end
   end

   assign memWrite     = mem_write_q;
   assign memRead      = mem_read_q;
   assign memAddress   = mem_addr_q;
   assign memWriteData = mem_wdata_q;
   assign aDone        = a_done_q;
   assign bDone        = b_done_q;
   assign aRdata       = a_rdata_q;
   assign bRdata       = b_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - directed vector bench for data_mem_arbiter
module tb_data_mem_arbiter;

   logic        Clk = 1'b0;
   logic        reset;
   logic        aReq, aWrite, bReq, bWrite;
   logic [31:0] aAddr, aWdata, bAddr, bWdata;
   logic        aDone, bDone, memWrite, memRead;
   logic [31:0] aRdata, bRdata, memAddress, memWriteData, memReadData;

   logic [31:0] mem [0:15];

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] E0 = 32'hE0000000;
   localparam logic [31:0] FF = 32'hFFFFFFFF;
   localparam logic [31:0] D2 = 32'h22222222;
   localparam logic [31:0] D3 = 32'h00000033;
   localparam logic [31:0] DA = 32'hAAAAAAAA;

   always #5 Clk = ~Clk;

   data_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .Clk(Clk), .reset(reset),
      .aReq(aReq), .aWrite(aWrite), .aAddr(aAddr), .aWdata(aWdata), .aDone(aDone), .aRdata(aRdata),
      .bReq(bReq), .bWrite(bWrite), .bAddr(bAddr), .bWdata(bWdata), .bDone(bDone), .bRdata(bRdata),
      .memWrite(memWrite), .memRead(memRead), .memAddress(memAddress),
      .memWriteData(memWriteData), .memReadData(memReadData)
   );

   assign memReadData = (memRead && memAddress < 32'd16) ? mem[memAddress[3:0]] : 32'h0;

   always @(posedge Clk) begin
      if (memWrite && memAddress < 32'd16) mem[memAddress[3:0]] <= memWriteData;
   end

   typedef struct {
      logic        rst;
      logic        ar, aw;
      logic [31:0] aa, ad;
      logic        br, bw;
      logic [31:0] ba, bd;
      logic        ew, er;
      logic [31:0] ema, emd;
      logic        ead, ebd;
      logic [31:0] ear, ebr;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rst, input logic ar, input logic aw, input logic [31:0] aa,
                               input logic [31:0] ad, input logic br, input logic bw, input logic [31:0] ba,
                               input logic [31:0] bd, input logic ew, input logic er, input logic [31:0] ema,
                               input logic [31:0] emd, input logic ead, input logic ebd,
                               input logic [31:0] ear, input logic [31:0] ebr);
      vec_t v;
      v.rst = rst; v.ar = ar; v.aw = aw; v.aa = aa; v.ad = ad;
      v.br = br; v.bw = bw; v.ba = ba; v.bd = bd;
      v.ew = ew; v.er = er; v.ema = ema; v.emd = emd;
      v.ead = ead; v.ebd = ebd; v.ear = ear; v.ebr = ebr;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   int          nd;
   int          cyc_at [4];
   logic        who [4];

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      reset = 1'b1;
      aReq = 0; aWrite = 0; aAddr = 0; aWdata = 0;
      bReq = 0; bWrite = 0; bAddr = 0; bWdata = 0;

      // rst ar aw aa ad       br bw ba bd     | mw mr ma md      aD bD aR  bR
      vecs.push_back(mk(1, 0,0,0,0,  0,0,0,0,   0,0,0,0,   0,0,0,0));
      // single write by A
      vecs.push_back(mk(0, 1,1,7,E0, 0,0,0,0,   1,0,7,E0,  0,0,0,0));
      vecs.push_back(mk(0, 1,1,7,E0, 0,0,0,0,   0,0,0,0,   1,0,0,0));
      vecs.push_back(mk(0, 0,0,0,0,  0,0,0,0,   0,0,0,0,   0,0,0,0));
      // B write then read back
      vecs.push_back(mk(0, 0,0,0,0,  1,1,6,FF,  1,0,6,FF,  0,0,0,0));
      vecs.push_back(mk(0, 0,0,0,0,  1,1,6,FF,  0,0,0,0,   0,1,0,0));
      vecs.push_back(mk(0, 0,0,0,0,  1,0,6,0,   0,0,0,0,   0,0,0,0));
      vecs.push_back(mk(0, 0,0,0,0,  1,0,6,0,   0,1,6,0,   0,0,0,0));
      vecs.push_back(mk(0, 0,0,0,0,  1,0,6,0,   0,0,0,0,   0,1,0,FF));
      vecs.push_back(mk(0, 0,0,0,0,  0,0,0,0,   0,0,0,0,   0,0,0,FF));
      // contention out of reset: A reads 7, B writes 2
      vecs.push_back(mk(1, 1,0,7,0,  1,1,2,D2,  0,0,0,0,   0,0,0,0));
      vecs.push_back(mk(0, 1,0,7,0,  1,1,2,D2,  0,1,7,0,   0,0,0,0));
      vecs.push_back(mk(0, 1,0,7,0,  1,1,2,D2,  0,0,0,0,   1,0,E0,0));
      vecs.push_back(mk(0, 1,0,7,0,  1,1,2,D2,  0,0,0,0,   0,0,E0,0));
      vecs.push_back(mk(0, 1,0,7,0,  1,1,2,D2,  1,0,2,D2,  0,0,E0,0));
      vecs.push_back(mk(0, 1,0,7,0,  1,1,2,D2,  0,0,0,0,   0,1,E0,0));
      vecs.push_back(mk(0, 1,0,7,0,  1,1,2,D2,  0,0,0,0,   0,0,E0,0));
      vecs.push_back(mk(0, 1,0,7,0,  1,1,2,D2,  0,1,7,0,   0,0,E0,0));
      vecs.push_back(mk(0, 1,0,7,0,  1,1,2,D2,  0,0,0,0,   1,0,E0,0));
      vecs.push_back(mk(0, 1,0,7,0,  1,1,2,D2,  0,0,0,0,   0,0,E0,0));
      vecs.push_back(mk(0, 1,0,7,0,  1,1,2,D2,  1,0,2,D2,  0,0,E0,0));
      vecs.push_back(mk(0, 1,0,7,0,  1,1,2,D2,  0,0,0,0,   0,1,E0,0));
      vecs.push_back(mk(0, 0,0,0,0,  0,0,0,0,   0,0,0,0,   0,0,E0,0));
      // A holds req; B arrives during A's access and is served next
      vecs.push_back(mk(0, 1,1,3,D3, 0,0,0,0,   1,0,3,D3,  0,0,E0,0));
      vecs.push_back(mk(0, 1,1,3,D3, 1,0,3,0,   0,0,0,0,   1,0,E0,0));
      vecs.push_back(mk(0, 1,1,3,D3, 1,0,3,0,   0,0,0,0,   0,0,E0,0));
      vecs.push_back(mk(0, 1,1,3,D3, 1,0,3,0,   0,1,3,0,   0,0,E0,0));
      vecs.push_back(mk(0, 1,1,3,D3, 1,0,3,0,   0,0,0,0,   0,1,E0,D3));
      vecs.push_back(mk(0, 1,1,3,D3, 0,0,0,0,   0,0,0,0,   0,0,E0,D3));
      vecs.push_back(mk(0, 1,1,3,D3, 0,0,0,0,   1,0,3,D3,  0,0,E0,D3));
      vecs.push_back(mk(0, 1,1,3,D3, 0,0,0,0,   0,0,0,0,   1,0,E0,D3));
      vecs.push_back(mk(0, 0,0,0,0,  0,0,0,0,   0,0,0,0,   0,0,E0,D3));
      // reset during ACCESS of a write to 8 (pointer was B)
      vecs.push_back(mk(0, 1,1,8,DA, 0,0,0,0,   1,0,8,DA,  0,0,E0,D3));
      vecs.push_back(mk(1, 1,1,8,DA, 0,0,0,0,   0,0,0,0,   0,0,0,0));
      vecs.push_back(mk(0, 0,0,0,0,  0,0,0,0,   0,0,0,0,   0,0,0,0));
      vecs.push_back(mk(0, 1,0,7,0,  1,0,6,0,   0,1,7,0,   0,0,0,0));
      vecs.push_back(mk(0, 1,0,7,0,  1,0,6,0,   0,0,0,0,   1,0,E0,0));
      vecs.push_back(mk(0, 0,0,0,0,  1,0,6,0,   0,0,0,0,   0,0,E0,0));
      vecs.push_back(mk(0, 0,0,0,0,  1,0,6,0,   0,1,6,0,   0,0,E0,0));
      vecs.push_back(mk(0, 0,0,0,0,  1,0,6,0,   0,0,0,0,   0,1,E0,FF));
      vecs.push_back(mk(0, 0,0,0,0,  0,0,0,0,   0,0,0,0,   0,0,E0,FF));
      // one-cycle request pulse still completes exactly once
      vecs.push_back(mk(1, 0,0,0,0,  0,0,0,0,   0,0,0,0,   0,0,0,0));
      vecs.push_back(mk(0, 1,0,7,0,  0,0,0,0,   0,1,7,0,   0,0,0,0));
      vecs.push_back(mk(0, 0,0,0,0,  0,0,0,0,   0,0,0,0,   1,0,E0,0));
      vecs.push_back(mk(0, 0,0,0,0,  0,0,0,0,   0,0,0,0,   0,0,E0,0));
      vecs.push_back(mk(0, 0,0,0,0,  0,0,0,0,   0,0,0,0,   0,0,E0,0));

      foreach (vecs[i]) begin
         reset = vecs[i].rst;
         aReq = vecs[i].ar; aWrite = vecs[i].aw; aAddr = vecs[i].aa; aWdata = vecs[i].ad;
         bReq = vecs[i].br; bWrite = vecs[i].bw; bAddr = vecs[i].ba; bWdata = vecs[i].bd;
         step();
         chk($sformatf("v%0d memWrite", i), {31'b0, memWrite}, {31'b0, vecs[i].ew});
         chk($sformatf("v%0d memRead", i), {31'b0, memRead}, {31'b0, vecs[i].er});
         chk($sformatf("v%0d memAddress", i), memAddress, vecs[i].ema);
         chk($sformatf("v%0d memWriteData", i), memWriteData, vecs[i].emd);
         chk($sformatf("v%0d aDone", i), {31'b0, aDone}, {31'b0, vecs[i].ead});
         chk($sformatf("v%0d bDone", i), {31'b0, bDone}, {31'b0, vecs[i].ebd});
         chk($sformatf("v%0d aRdata", i), aRdata, vecs[i].ear);
         chk($sformatf("v%0d bRdata", i), bRdata, vecs[i].ebr);
      end

      // Sustained contention: both sides hold requests, dones must alternate every 3 cycles
      reset = 1'b1;
      aReq = 0; bReq = 0;
      step();
      reset = 1'b0;
      aReq = 1; aWrite = 0; aAddr = 7; aWdata = 0;
      bReq = 1; bWrite = 0; bAddr = 6; bWdata = 0;
      nd = 0;
      for (int c = 1; c <= 30 && nd < 4; c++) begin
         step();
         chk($sformatf("alt c%0d cmd exclusive", c), {31'b0, memWrite & memRead}, 32'h0);
         if (aDone || bDone) begin
            chk($sformatf("alt c%0d single done", c), {31'b0, aDone & bDone}, 32'h0);
            who[nd]    = bDone;
            cyc_at[nd] = c;
            nd++;
         end
      end
      chk("alt done count", nd, 4);
      if (nd > 0) chk("alt first done cycle", cyc_at[0], 2);
      for (int k = 0; k < 4; k++) begin
         if (k < nd) chk($sformatf("alt done%0d side", k), {31'b0, who[k]}, k % 2);
         if (k > 0 && k < nd) chk($sformatf("alt done%0d spacing", k), cyc_at[k] - cyc_at[k-1], 3);
      end
      chk("alt aRdata", aRdata, E0);
      chk("alt bRdata", bRdata, FF);
      aReq = 0; bReq = 0;
      step();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
